// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 timing and framebuffer geometry
// shared by the VGA framebuffer scanout slice.
package vga_pkg;

    localparam logic [9:0] H_ACTIVE_D = 10'd640;
    localparam logic [9:0] H_FP_D     = 10'd16;
    localparam logic [9:0] H_SYNC_D   = 10'd96;
    localparam logic [9:0] H_BP_D     = 10'd48;

    localparam logic [9:0] V_ACTIVE_D = 10'd480;
    localparam logic [9:0] V_FP_D     = 10'd10;
    localparam logic [9:0] V_SYNC_D   = 10'd2;
    localparam logic [9:0] V_BP_D     = 10'd33;

    localparam logic [9:0] H_TOTAL = 10'd800;
    localparam logic [9:0] V_TOTAL = 10'd525;

    localparam logic [12:0] BLOCKS_PER_ROW = 13'd80;
    localparam int          FB_WORDS       = 150;

endpackage

// File: rtl/vga_fb_scanout_timing.sv
// vga_timing_gen: pixel-tick divider, h/v counters and the raw
// (unpipelined) active and sync terms for the scanout.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int         CLK_DIV  = 2,
    parameter logic [9:0] H_ACTIVE = H_ACTIVE_D,
    parameter logic [9:0] H_FP     = H_FP_D,
    parameter logic [9:0] H_SYNC   = H_SYNC_D,
    parameter logic [9:0] H_BP     = H_BP_D,
    parameter logic [9:0] V_ACTIVE = V_ACTIVE_D,
    parameter logic [9:0] V_FP     = V_FP_D,
    parameter logic [9:0] V_SYNC   = V_SYNC_D,
    parameter logic [9:0] V_BP     = V_BP_D
) (
    input  logic       clk,
    input  logic       rst,
    output logic       tick,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       active,
    output logic       hs,
    output logic       vs
);

    localparam logic [1:0] DIV_LAST = 2'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = H_ACTIVE + H_FP + H_SYNC + H_BP - 10'd1;
    localparam logic [9:0] V_LAST   = V_ACTIVE + V_FP + V_SYNC + V_BP - 10'd1;
    localparam logic [9:0] HS_FIRST = H_ACTIVE + H_FP;
    localparam logic [9:0] HS_LAST  = H_ACTIVE + H_FP + H_SYNC - 10'd1;
    localparam logic [9:0] VS_FIRST = V_ACTIVE + V_FP;
    localparam logic [9:0] VS_LAST  = V_ACTIVE + V_FP + V_SYNC - 10'd1;

    logic [1:0] div;

    assign tick = (div == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            div <= 2'd0;
        end else if (tick) begin
            div <= 2'd0;
        end else begin
            div <= div + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= 10'd0;
            v_cnt <= 10'd0;
        end else if (tick) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= 10'd0;
                v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    assign active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE);
    assign hs     = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
    assign vs     = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));

endmodule

// File: rtl/vga_fb_scanout.sv
// vga_fb_scanout: scans a 1-bit-per-8x8-block framebuffer through the
// memory's combinational test port and emits aligned VGA pixels.
module vga_fb_scanout
    import vga_pkg::*;
#(
    parameter int                       RAM_ADDR_BITS = 10,
    parameter logic [RAM_ADDR_BITS-1:0] FB_BASE       = 10'h300,
    parameter int                       CLK_DIV       = 2,
    parameter logic [9:0]               H_ACTIVE      = H_ACTIVE_D,
    parameter logic [9:0]               H_FP          = H_FP_D,
    parameter logic [9:0]               H_SYNC        = H_SYNC_D,
    parameter logic [9:0]               H_BP          = H_BP_D,
    parameter logic [9:0]               V_ACTIVE      = V_ACTIVE_D,
    parameter logic [9:0]               V_FP          = V_FP_D,
    parameter logic [9:0]               V_SYNC        = V_SYNC_D,
    parameter logic [9:0]               V_BP          = V_BP_D,
    parameter logic [2:0]               FG_RGB        = 3'b111,
    parameter logic [2:0]               BG_RGB        = 3'b000
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [RAM_ADDR_BITS-1:0] fb_addr,
    input  logic [31:0]              fb_data,
    output logic                     hsync,
    output logic                     vsync,
    output logic                     video_on,
    output logic [2:0]               rgb,
    output logic                     frame_start
);

    localparam logic [9:0] H_LAST = H_ACTIVE + H_FP + H_SYNC + H_BP - 10'd1;
    localparam logic [9:0] V_LAST = V_ACTIVE + V_FP + V_SYNC + V_BP - 10'd1;

    logic        tick;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic        active;
    logic        hs;
    logic        vs;

    logic        h_wrap;
    logic        v_wrap;
    logic [12:0] row_base;
    logic [12:0] idx;

    logic [4:0]  sel;
    logic        active1;
    logic        hs1;
    logic        vs1;
    logic        first1;

    vga_timing_gen #(
        .CLK_DIV  (CLK_DIV),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk    (clk),
        .rst    (rst),
        .tick   (tick),
        .h_cnt  (h_cnt),
        .v_cnt  (v_cnt),
        .active (active),
        .hs     (hs),
        .vs     (vs)
    );

    assign h_wrap = tick && (h_cnt == H_LAST);
    assign v_wrap = h_wrap && (v_cnt == V_LAST);
    assign idx    = row_base + {6'd0, h_cnt[9:3]};

    // row_base steps one block row after the eighth line of each row
    always_ff @(posedge clk) begin
        if (rst || v_wrap) begin
            row_base <= 13'd0;
        end else if (h_wrap && (v_cnt < V_ACTIVE) && (v_cnt[2:0] == 3'd7)) begin
            row_base <= row_base + BLOCKS_PER_ROW;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fb_addr <= FB_BASE;
            sel     <= 5'd0;
            active1 <= 1'b0;
            hs1     <= 1'b1;
            vs1     <= 1'b1;
            first1  <= 1'b0;
        end else if (tick) begin
            active1 <= active;
            hs1     <= hs;
            vs1     <= vs;
            first1  <= (h_cnt == 10'd0) && (v_cnt == 10'd0);
            if (active) begin
                fb_addr <= FB_BASE + RAM_ADDR_BITS'(idx[12:5]);
                sel     <= idx[4:0];
            end
        end
    end

    // fb_data already reflects fb_addr from the previous tick
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb         <= 3'b000;
            video_on    <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= tick && first1;
            if (tick) begin
                video_on <= active1;
                hsync    <= hs1;
                vsync    <= vs1;
                rgb      <= active1 ? (fb_data[sel] ? FG_RGB : BG_RGB) : 3'b000;
            end
        end
    end

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Bench for vga_fb_scanout: reduced timing, combinational memory model,
// per-cycle reference computed from pixel position arithmetic.
module tb_vga_fb_scanout;

    localparam int DIV   = 2;
    localparam int HA    = 64;
    localparam int HF    = 8;
    localparam int HSW   = 16;
    localparam int HB    = 8;
    localparam int HT    = HA + HF + HSW + HB;
    localparam int VA    = 24;
    localparam int VF    = 2;
    localparam int VSW   = 2;
    localparam int VB    = 2;
    localparam int VT    = VA + VF + VSW + VB;
    localparam int FRAME = HT * VT;
    localparam int BASE  = 'h300;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  fb_addr;
    logic [31:0] fb_data;
    logic        hsync;
    logic        vsync;
    logic        video_on;
    logic [2:0]  rgb;
    logic        frame_start;

    logic [31:0] mem [0:1023];

    assign fb_data = mem[fb_addr];

    always #5 clk = ~clk;

    vga_fb_scanout #(
        .RAM_ADDR_BITS (10),
        .FB_BASE       (10'h300),
        .CLK_DIV       (DIV),
        .H_ACTIVE      (10'(HA)),
        .H_FP          (10'(HF)),
        .H_SYNC        (10'(HSW)),
        .H_BP          (10'(HB)),
        .V_ACTIVE      (10'(VA)),
        .V_FP          (10'(VF)),
        .V_SYNC        (10'(VSW)),
        .V_BP          (10'(VB)),
        .FG_RGB        (3'b111),
        .BG_RGB        (3'b000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .hsync       (hsync),
        .vsync       (vsync),
        .video_on    (video_on),
        .rgb         (rgb),
        .frame_start (frame_start)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Pixel (h,v) lights when its block bit is set; bit 0 is the leftmost block.
    function automatic logic pix(input int h, input int v);
        int bi;
        bi = (v / 8) * 80 + h / 8;
        return mem[BASE + bi / 32][bi % 32];
    endfunction

    int          c;
    int          k;
    int          n;
    int          h;
    int          v;
    int          n1;
    int          h1;
    int          v1;
    int          mh = -1;
    int          mv = -1;
    bit          r;
    bit          tk;
    bit          eon;
    bit          ehs;
    bit          evs;
    bit          efs;
    logic [2:0]  ergb;
    logic [31:0] exp_addr;
    logic [9:0]  max_addr;

    int since_fs;
    int tpos;
    int hs_cnt;
    int vs_cnt;
    int lit_cnt;
    int first_lit;
    int snap_period;
    int snap_hs;
    int snap_vs;
    int snap_lit;
    int snap_first;

    // Model: output position after tick k is linear pixel k-2 of the frame.
    always begin
        @(posedge clk);
        r = rst;
        #1;
        if (r) begin
            c = 0;
            exp_addr = 32'(BASE);
            max_addr = 10'(BASE);
            since_fs = 0;
            tpos = 0;
            hs_cnt = 0;
            vs_cnt = 0;
            lit_cnt = 0;
            first_lit = -1;
            mh = -1;
            mv = -1;
            eon = 1'b0;
            ehs = 1'b1;
            evs = 1'b1;
            ergb = 3'b000;
            efs = 1'b0;
        end else begin
            c++;
            tk = (c % DIV) == 0;
            k = c / DIV;
            if (tk && k >= 1) begin
                n1 = (k - 1) % FRAME;
                h1 = n1 % HT;
                v1 = n1 / HT;
                if (h1 < HA && v1 < VA)
                    exp_addr = 32'(BASE + ((v1 / 8) * 80 + h1 / 8) / 32);
            end
            if (k >= 2) begin
                n = (k - 2) % FRAME;
                h = n % HT;
                v = n / HT;
                mh = h;
                mv = v;
                eon = (h < HA) && (v < VA);
                ehs = !((h >= HA + HF) && (h < HA + HF + HSW));
                evs = !((v >= VA + VF) && (v < VA + VF + VSW));
                ergb = (eon && pix(h, v)) ? 3'b111 : 3'b000;
                efs = tk && (n == 0);
            end else begin
                eon = 1'b0;
                ehs = 1'b1;
                evs = 1'b1;
                ergb = 3'b000;
                efs = 1'b0;
            end
            since_fs++;
            if (frame_start) begin
                snap_period = since_fs;
                snap_hs = hs_cnt;
                snap_vs = vs_cnt;
                snap_lit = lit_cnt;
                snap_first = first_lit;
                since_fs = 0;
                tpos = 0;
                hs_cnt = 0;
                vs_cnt = 0;
                lit_cnt = 0;
                first_lit = -1;
            end else if (tk) begin
                tpos++;
            end
            if (tk && k >= 2) begin
                if (!hsync) hs_cnt++;
                if (!vsync) vs_cnt++;
                if (rgb == 3'b111) begin
                    if (lit_cnt == 0) first_lit = tpos;
                    lit_cnt++;
                end
            end
            if (fb_addr > max_addr) max_addr = fb_addr;
        end
        chk("video_on", 32'(video_on), 32'(eon));
        chk("hsync", 32'(hsync), 32'(ehs));
        chk("vsync", 32'(vsync), 32'(evs));
        chk("rgb", 32'(rgb), 32'(ergb));
        chk("frame_start", 32'(frame_start), 32'(efs));
        chk("fb_addr", 32'(fb_addr), exp_addr);
    end

    task automatic wait_fs(input int budget, output int d);
        d = 0;
        forever begin
            @(posedge clk);
            #2;
            d++;
            if (frame_start) return;
            if (d >= budget) begin
                tests++;
                fails++;
                $display("FAIL fs_timeout: no frame_start within %0d clks", budget);
                return;
            end
        end
    endtask

    task automatic begin_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic end_reset(input int clks);
        repeat (clks) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clear_fb();
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    endtask

    // One full frame after reset, then the per-frame literal statistics.
    task automatic run_frame(input string tag, input int exp_first);
        int d;
        wait_fs(20, d);
        chk({tag, "_first_fs_clks"}, 32'(d), 32'd4);
        wait_fs(FRAME * DIV + 20, d);
        chk({tag, "_fs_period"}, 32'(snap_period), 32'(FRAME * DIV));
        chk({tag, "_hs_low_ticks"}, 32'(snap_hs), 32'(HSW * VT));
        chk({tag, "_vs_low_ticks"}, 32'(snap_vs), 32'(VSW * HT));
        chk({tag, "_lit_pixels"}, 32'(snap_lit), 32'd64);
        chk({tag, "_first_lit"}, 32'(snap_first), 32'(exp_first));
    endtask

    initial begin
        int d;
        int cnt;
        clear_fb();

        // single lit block at the top-left corner
        mem[BASE] = 32'h0000_0001;
        end_reset(5);
        run_frame("corner", 0);

        // idx 80: column 0 of block row 1, third word
        begin_reset();
        clear_fb();
        mem[BASE + 2] = 32'h0001_0000;
        end_reset(4);
        run_frame("row1", 8 * HT);

        // last block of the reduced frame: row 2, col 7 -> idx 167
        begin_reset();
        clear_fb();
        mem[BASE + 5] = 32'h0000_0080;
        end_reset(4);
        run_frame("last", 16 * HT + 56);
        chk("last_max_addr", 32'(max_addr), 32'h305);

        // random framebuffer, checked by the per-cycle model
        begin_reset();
        for (int i = 0; i < 150; i++) mem[BASE + i] = $urandom;
        end_reset(3);
        wait_fs(20, d);
        wait_fs(FRAME * DIV + 20, d);
        chk("rand_fs_period", 32'(snap_period), 32'(FRAME * DIV));

        // one-clk reset in the middle of a line
        cnt = 0;
        while (!(mh == 40 && mv == 12) && cnt < FRAME * DIV * 2) begin
            @(negedge clk);
            cnt++;
        end
        chk("midreset_reached", 32'(mh == 40 && mv == 12), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_fs(20, d);
        chk("midreset_first_fs_clks", 32'(d), 32'd4);
        wait_fs(FRAME * DIV + 20, d);
        chk("midreset_fs_period", 32'(snap_period), 32'(FRAME * DIV));
        chk("midreset_hs_low_ticks", 32'(snap_hs), 32'(HSW * VT));

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
